// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM for the MIPS core.
// Moves one instruction through FETCH / DECODE / EXE / MEM / WB and drives the
// datapath strobes and mux selects. It waits on the instruction-memory and
// data-memory ready handshakes and counts retired instructions.
// Optional build macro ILLEGAL_TRAP_EN: an illegal opcode or funct enters a
// sticky TRAP state and raises 'illegal'. Without it, the instruction retires
// as a NOP.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic             DMRd,
    output logic [1:0]       NPCOp,
    output logic [1:0]       EXTOp,
    output logic [2:0]       ALUOp,
    output logic             Bsel,
    output logic [1:0]       WDSel,
    output logic [1:0]       GPRSel,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    state_t state_q;
    state_t state_n;

    logic       is_rtype;
    logic       is_ori;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_j;
    logic       is_jal;
    logic       funct_ok;
    logic [2:0] r_alu_op;

    assign is_rtype = (OP == OP_RTYPE);
    assign is_ori   = (OP == OP_ORI);
    assign is_lw    = (OP == OP_LW);
    assign is_sw    = (OP == OP_SW);
    assign is_beq   = (OP == OP_BEQ);
    assign is_j     = (OP == OP_J);
    assign is_jal   = (OP == OP_JAL);

    // Map R-type funct to ALU operation and flag unsupported functs.
    always_comb begin
        funct_ok = 1'b1;
        r_alu_op = 3'b000;
        unique case (Funct)
            6'h21:   r_alu_op = 3'b000;  // addu
            6'h23:   r_alu_op = 3'b001;  // subu
            6'h24:   r_alu_op = 3'b011;  // and
            6'h25:   r_alu_op = 3'b010;  // or
            6'h27:   r_alu_op = 3'b101;  // nor
            6'h2a:   r_alu_op = 3'b100;  // slt
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state and Moore output decode; reset masks every strobe and select.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_n    = state_q;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RFWr       = 1'b0;
        DMWr       = 1'b0;
        DMRd       = 1'b0;
        NPCOp      = 2'b00;
        EXTOp      = 2'b00;
        ALUOp      = 3'b000;
        Bsel       = 1'b0;
        WDSel      = 2'b00;
        GPRSel     = 2'b00;
        instr_done = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                PCWr = im_ready;
                IRWr = im_ready;
                if (im_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                if (is_rtype || is_ori || is_lw || is_sw) begin
                    state_n = S_EXE;
                end else if (is_beq) begin
                    state_n = S_BRANCH;
                end else if (is_j || is_jal) begin
                    state_n = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_n = S_TRAP;
`else
                    instr_done = 1'b1;
                    state_n    = S_FETCH;
`endif
                end
            end
            S_EXE: begin
                if (is_rtype) begin
                    Bsel = 1'b0;
                    if (funct_ok) begin
                        ALUOp   = r_alu_op;
                        state_n = S_WB;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_n = S_TRAP;
`else
                        instr_done = 1'b1;
                        state_n    = S_FETCH;
`endif
                    end
                end else if (is_ori) begin
                    Bsel    = 1'b1;
                    EXTOp   = 2'b00;
                    ALUOp   = 3'b010;
                    state_n = S_WB;
                end else if (is_lw || is_sw) begin
                    Bsel    = 1'b1;
                    EXTOp   = 2'b01;
                    ALUOp   = 3'b000;
                    state_n = is_lw ? S_MEM_RD : S_MEM_WR;
                end else begin
                    // Opcode changed under us; abandon the instruction.
                    state_n = S_FETCH;
                end
            end
            S_MEM_RD: begin
                DMRd = 1'b1;
                if (dm_ready) state_n = S_WB;
            end
            S_MEM_WR: begin
                DMWr = 1'b1;
                if (dm_ready) begin
                    instr_done = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_WB: begin
                RFWr       = 1'b1;
                instr_done = 1'b1;
                GPRSel     = is_rtype ? 2'b00 : 2'b01;
                WDSel      = is_lw    ? 2'b01 : 2'b00;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                ALUOp      = 3'b001;
                Bsel       = 1'b0;
                EXTOp      = 2'b01;
                NPCOp      = 2'b01;
                PCWr       = Zero;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_JUMP: begin
                NPCOp      = 2'b10;
                PCWr       = 1'b1;
                instr_done = 1'b1;
                if (is_jal) begin
                    // Link value is the PC that FETCH already advanced.
                    RFWr   = 1'b1;
                    GPRSel = 2'b10;
                    WDSel  = 2'b10;
                end
                state_n = S_FETCH;
            end
            S_TRAP: begin
                state_n = S_TRAP;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        if (rst) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            RFWr       = 1'b0;
            DMWr       = 1'b0;
            DMRd       = 1'b0;
            NPCOp      = 2'b00;
            EXTOp      = 2'b00;
            ALUOp      = 3'b000;
            Bsel       = 1'b0;
            WDSel      = 2'b00;
            GPRSel     = 2'b00;
            instr_done = 1'b0;
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_n;
            retired <= retired + {{(CNT_W-1){1'b0}}, instr_done};
        end
    end

    assign state = state_q;

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (state_n == S_TRAP) begin
            illegal <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm. For each cycle, the stimulus process
// predicts the full output picture from an instruction-level model and pushes
// it into a scoreboard queue. A monitor pops one entry per falling edge and
// compares it with the DUT.
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;  // narrow so counter wrap is exercised

    typedef struct packed {
        logic [3:0]       state;
        logic             pcwr;
        logic             irwr;
        logic             rfwr;
        logic             dmwr;
        logic             dmrd;
        logic [1:0]       npcop;
        logic [1:0]       extop;
        logic [2:0]       aluop;
        logic             bsel;
        logic [1:0]       wdsel;
        logic [1:0]       gprsel;
        logic             instr_done;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } obs_t;

    typedef enum {K_R, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD_OP, K_BAD_FN} kind_t;

    logic clk, rst;
    logic [5:0] OP, Funct;
    logic Zero, im_ready, dm_ready;
    logic PCWr, IRWr, RFWr, DMWr, DMRd, Bsel, instr_done, illegal;
    logic [1:0] NPCOp, EXTOp, WDSel, GPRSel;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic [CNT_W-1:0] retired;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Funct(Funct), .Zero(Zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .DMRd(DMRd),
        .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp), .Bsel(Bsel),
        .WDSel(WDSel), .GPRSel(GPRSel), .state(state),
        .instr_done(instr_done), .retired(retired), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cycle_no = 0;

    // Model state: retired count, illegal flag, and directed-test knobs.
    logic [CNT_W-1:0] model_ret = '0;
    logic             model_ill = 1'b0;
    int  im_stall   = -1;   // -1: random, else number of low cycles
    int  dm_stall   = -1;
    int  zero_force = -1;
    bit  abort_mem  = 1'b0;

    // Monitor: one expected picture per cycle, compared away from the edge.
    obs_t  mon_e, mon_g;
    string mon_n;
    always @(negedge clk) begin
        cycle_no++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_g = {state, PCWr, IRWr, RFWr, DMWr, DMRd, NPCOp, EXTOp, ALUOp,
                     Bsel, WDSel, GPRSel, instr_done, illegal, retired};
            checks++;
            if (mon_g !== mon_e) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h required=%h (state got=%0d required=%0d)",
                         mon_n, cycle_no, mon_g, mon_e, mon_g.state, mon_e.state);
            end
        end
    end

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a}) ? K_R : K_BAD_FN;
            6'h0d:   return K_ORI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_BAD_OP;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h23:   return 3'b001;
            6'h24:   return 3'b011;
            6'h25:   return 3'b010;
            6'h27:   return 3'b101;
            6'h2a:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] st);
        obs_t e;
        e         = '0;
        e.state   = st;
        e.retired = model_ret;
        e.illegal = model_ill;
        return e;
    endfunction

    task automatic rand_side();
        im_ready = 1'($urandom_range(0, 1));
        dm_ready = 1'($urandom_range(0, 1));
        Zero     = 1'($urandom_range(0, 1));
    endtask

    task automatic step(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_cycle(input logic [3:0] st, input string nm);
        obs_t e;
        rst = 1'b1;
        rand_side();
        e = mk(st);
        step(e, nm);
        rst       = 1'b0;
        model_ret = '0;
        model_ill = 1'b0;
    endtask

    task automatic do_trap();
        obs_t e;
        model_ill = 1'b1;
        repeat (10) begin
            rand_side();
            e = mk(4'd8);
            step(e, "trap_hold");
        end
        do_reset_cycle(4'd8, "trap_reset");
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        obs_t  e;
        int    n;
        logic  rdy;
        k     = classify(op, fn);
        OP    = op;
        Funct = fn;

        // Fetch: PC and IR written in the cycle the instruction word arrives.
        n = 0;
        while (1) begin
            rand_side();
            im_ready = (im_stall < 0) ? (n >= 4 || $urandom_range(0, 3) != 0) : (n >= im_stall);
            rdy    = im_ready;
            e      = mk(4'd0);
            e.pcwr = rdy;
            e.irwr = rdy;
            step(e, "fetch");
            if (rdy) break;
            n++;
        end

        // Decode: silent, except that an illegal opcode retires as a NOP.
        rand_side();
        e = mk(4'd1);
        if (k == K_BAD_OP) begin
`ifdef ILLEGAL_TRAP_EN
            step(e, "decode_bad_op");
            do_trap();
`else
            e.instr_done = 1'b1;
            step(e, "decode_bad_op");
            model_ret++;
`endif
            return;
        end
        step(e, "decode");

        if (k == K_BEQ) begin
            rand_side();
            if (zero_force >= 0) Zero = (zero_force != 0);
            e            = mk(4'd6);
            e.aluop      = 3'b001;
            e.extop      = 2'b01;
            e.npcop      = 2'b01;
            e.pcwr       = Zero;
            e.instr_done = 1'b1;
            step(e, "branch");
            model_ret++;
            return;
        end

        if (k == K_J || k == K_JAL) begin
            rand_side();
            e            = mk(4'd7);
            e.npcop      = 2'b10;
            e.pcwr       = 1'b1;
            e.instr_done = 1'b1;
            if (k == K_JAL) begin
                e.rfwr   = 1'b1;
                e.gprsel = 2'b10;
                e.wdsel  = 2'b10;
            end
            step(e, "jump");
            model_ret++;
            return;
        end

        // Execute.
        rand_side();
        e = mk(4'd2);
        case (k)
            K_R:        e.aluop = r_alu(fn);
            K_ORI:      begin e.bsel = 1'b1; e.aluop = 3'b010; end
            K_LW, K_SW: begin e.bsel = 1'b1; e.extop = 2'b01; end
            default:    ;
        endcase
        if (k == K_BAD_FN) begin
`ifdef ILLEGAL_TRAP_EN
            step(e, "exe_bad_funct");
            do_trap();
`else
            e.instr_done = 1'b1;
            step(e, "exe_bad_funct");
            model_ret++;
`endif
            return;
        end
        step(e, "exe");

        // Memory access with ready-handshake stall.
        if (k == K_LW || k == K_SW) begin
            n = 0;
            while (1) begin
                if (abort_mem && n == 1) begin
                    do_reset_cycle((k == K_LW) ? 4'd3 : 4'd4, "mem_abort");
                    return;
                end
                rand_side();
                if (abort_mem)
                    dm_ready = 1'b0;
                else
                    dm_ready = (dm_stall < 0) ? (n >= 4 || $urandom_range(0, 2) != 0) : (n >= dm_stall);
                rdy = dm_ready;
                if (k == K_LW) begin
                    e      = mk(4'd3);
                    e.dmrd = 1'b1;
                end else begin
                    e            = mk(4'd4);
                    e.dmwr       = 1'b1;
                    e.instr_done = rdy;
                end
                step(e, (k == K_LW) ? "mem_rd" : "mem_wr");
                if (rdy) break;
                n++;
            end
            if (k == K_SW) begin
                model_ret++;
                return;
            end
        end

        // Write back.
        rand_side();
        e            = mk(4'd5);
        e.rfwr       = 1'b1;
        e.instr_done = 1'b1;
        e.gprsel     = (k == K_R)  ? 2'b00 : 2'b01;
        e.wdsel      = (k == K_LW) ? 2'b01 : 2'b00;
        step(e, "wb");
        model_ret++;
    endtask

    logic [5:0] legal_fn [6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a};

    initial begin
        obs_t       e;
        logic [5:0] op, fn;
        int         r;

        rst = 1'b1; OP = '0; Funct = '0; Zero = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset_cycle(4'd0, "reset_state");

        // Directed cases.
        im_stall = 0; dm_stall = 0;
        run_instr(6'h00, 6'h21);                  // addu: 4 cycles
        dm_stall = 3;
        run_instr(6'h23, 6'h00);                  // lw with 3 stall cycles
        dm_stall = 0;
        zero_force = 1; run_instr(6'h04, 6'h00);  // beq taken
        zero_force = 0; run_instr(6'h04, 6'h00);  // beq not taken
        zero_force = -1;
        run_instr(6'h03, 6'h00);                  // jal
        abort_mem = 1'b1;
        run_instr(6'h2b, 6'h00);                  // sw aborted by reset in MEM_WR
        abort_mem = 1'b0;
        run_instr(6'h3f, 6'h00);                  // illegal opcode
        run_instr(6'h00, 6'h21);                  // recovery

        // Randomized instruction stream with random handshakes.
        im_stall = -1; dm_stall = -1;
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            fn = 6'($urandom_range(0, 63));
            case (r)
                6:       op = 6'h0d;
                7, 8:    op = 6'h23;
                9, 10:   op = 6'h2b;
                11, 12:  op = 6'h04;
                13:      op = 6'h02;
                14:      op = 6'h03;
                15: begin
                    do op = 6'($urandom_range(0, 63));
                    while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h23, 6'h2b});
                end
                16: begin
                    op = 6'h00;
                    while (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a})
                        fn = 6'($urandom_range(0, 63));
                end
                default: begin
                    op = 6'h00;
                    fn = legal_fn[$urandom_range(0, 5)];
                end
            endcase
            run_instr(op, fn);
        end

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
